// File: rtl/data_receiver_pkg.sv
// Shared definitions for the domain-B end of the req/ack multi-bit CDC handshake.
package data_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPT     = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_DATA_W      = 4;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/data_receiver_sync_ff.sv
// Single-bit synchronizer chain, reused for every bit-level crossing.
module sync_ff
    import data_receiver_pkg::*;
#(
    parameter int unsigned STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_d};
        end
    end

    assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/data_receiver.sv
// Domain-B receiver: synchronizes req, captures the held bus, returns ack,
// presents each word once to a valid/ready consumer and checks +1 sequencing.
module data_receiver
    import data_receiver_pkg::*;
#(
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int unsigned SEQ_CHECK   = 1
) (
    input  logic              i_clk_b,
    input  logic              i_rst,
    input  logic              i_data_req,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_data_ack,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    input  logic              i_rx_ready,
    output logic              o_seq_err,
    output logic [15:0]       o_xfer_cnt
);

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              seq_err_q, seq_err_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              armed_q, armed_d;

    logic req_s;
    logic space;
    logic capture;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .i_clk (i_clk_b),
        .i_rst (i_rst),
        .i_d   (i_data_req),
        .o_q   (req_s)
    );

    assign space   = !rx_valid_q || i_rx_ready;
    assign capture = (state_q == IDLE) && req_s && space;

    always_ff @(posedge i_clk_b) begin
        if (i_rst) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            seq_err_q  <= 1'b0;
            cnt_q      <= '0;
            last_q     <= '0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            seq_err_q  <= seq_err_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            armed_q    <= armed_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        seq_err_d  = seq_err_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        armed_d    = armed_q;

        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                ack_d   = 1'b1;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        // A capture on the same edge as an accept keeps valid high with the new word.
        if (capture) begin
            rx_valid_d = 1'b1;
            rx_data_d  = i_data;
            cnt_d      = cnt_q + 16'd1;
            if (SEQ_CHECK != 0) begin
                if (armed_q && (i_data != last_q + ONE)) begin
                    seq_err_d = 1'b1;
                end
                last_d  = i_data;
                armed_d = 1'b1;
            end
        end else if (rx_valid_q && i_rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    assign o_data_ack = ack_q;
    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;
    assign o_seq_err  = seq_err_q;
    assign o_xfer_cnt = cnt_q;

endmodule

// File: tb/tb_data_receiver.sv
// Directed bench for data_receiver: cycle table for the basic handshake plus
// hand-written sequences for streaming, backpressure, sequence break and reset.
module tb_data_receiver;

    logic        clk;
    logic        rst;
    logic        req;
    logic [3:0]  data;
    logic        ack;
    logic [3:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        seq_err;
    logic [15:0] xfer_cnt;

    int errors = 0;
    int checks = 0;

    logic       mon_en = 1'b0;
    logic [3:0] got_q[$];

    typedef struct {
        logic        req;
        logic [3:0]  data;
        logic        ready;
        logic        exp_valid;
        logic [3:0]  exp_data;
        logic        exp_ack;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[9];

    data_receiver #(
        .DATA_W      (4),
        .SYNC_STAGES (2),
        .SEQ_CHECK   (1)
    ) dut (
        .i_clk_b    (clk),
        .i_rst      (rst),
        .i_data_req (req),
        .i_data     (data),
        .o_data_ack (ack),
        .o_rx_data  (rx_data),
        .o_rx_valid (rx_valid),
        .i_rx_ready (rx_ready),
        .o_seq_err  (seq_err),
        .o_xfer_cnt (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mon_en && rx_valid && rx_ready) got_q.push_back(rx_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input logic level, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (ack === level) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) check(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rx_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) check(name, {31'd0, seen}, 32'd1);
    endtask

    // Domain-A driver: full 4-phase handshake for one word.
    task automatic send_word(input logic [3:0] w);
        data = w;
        req  = 1'b1;
        wait_ack(1'b1, "ack_rise_timeout");
        req = 1'b0;
        wait_ack(1'b0, "ack_fall_timeout");
    endtask

    initial begin
        //        req  data  rdy  valid edata ack  cnt
        tbl[0] = '{1'b1, 4'h3, 1'b1, 1'b0, 4'h0, 1'b0, 16'd0};
        tbl[1] = '{1'b1, 4'h3, 1'b1, 1'b0, 4'h0, 1'b0, 16'd0};
        tbl[2] = '{1'b1, 4'h3, 1'b1, 1'b1, 4'h3, 1'b0, 16'd1};
        tbl[3] = '{1'b1, 4'h3, 1'b1, 1'b0, 4'h3, 1'b1, 16'd1};
        tbl[4] = '{1'b1, 4'h3, 1'b1, 1'b0, 4'h3, 1'b1, 16'd1};
        tbl[5] = '{1'b0, 4'hA, 1'b1, 1'b0, 4'h3, 1'b1, 16'd1};
        tbl[6] = '{1'b0, 4'hA, 1'b1, 1'b0, 4'h3, 1'b1, 16'd1};
        tbl[7] = '{1'b0, 4'hA, 1'b1, 1'b0, 4'h3, 1'b0, 16'd1};
        tbl[8] = '{1'b0, 4'hA, 1'b1, 1'b0, 4'h3, 1'b0, 16'd1};

        rst      = 1'b1;
        req      = 1'b0;
        data     = 4'h0;
        rx_ready = 1'b1;
        @(negedge clk);
        do_reset();

        check("reset_ack",   {31'd0, ack},      32'd0);
        check("reset_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_data",  {28'd0, rx_data},  32'd0);
        check("reset_err",   {31'd0, seq_err},  32'd0);
        check("reset_cnt",   {16'd0, xfer_cnt}, 32'd0);

        // Basic handshake, one row per clock edge
        for (int i = 0; i < 9; i++) begin
            req      = tbl[i].req;
            data     = tbl[i].data;
            rx_ready = tbl[i].ready;
            tick();
            check($sformatf("basic_valid[%0d]", i), {31'd0, rx_valid}, {31'd0, tbl[i].exp_valid});
            check($sformatf("basic_data[%0d]", i),  {28'd0, rx_data},  {28'd0, tbl[i].exp_data});
            check($sformatf("basic_ack[%0d]", i),   {31'd0, ack},      {31'd0, tbl[i].exp_ack});
            check($sformatf("basic_cnt[%0d]", i),   {16'd0, xfer_cnt}, {16'd0, tbl[i].exp_cnt});
        end

        // Stream 0..15,0 with random gaps
        do_reset();
        rx_ready = 1'b1;
        got_q.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            repeat ($urandom_range(0, 8)) tick();
            send_word(4'(i));
        end
        repeat (3) tick();
        mon_en = 1'b0;
        check("stream_count", got_q.size(), 32'd17);
        for (int i = 0; i < 17 && i < got_q.size(); i++) begin
            check($sformatf("stream_word[%0d]", i), {28'd0, got_q[i]}, i % 16);
        end
        check("stream_err", {31'd0, seq_err},  32'd0);
        check("stream_cnt", {16'd0, xfer_cnt}, 32'd17);

        // Backpressure, then accept and capture on the same edge
        do_reset();
        rx_ready = 1'b0;
        got_q.delete();
        mon_en = 1'b1;
        send_word(4'h7);
        check("bp_held_valid", {31'd0, rx_valid}, 32'd1);
        data = 4'h8;
        req  = 1'b1;
        begin
            int ack_seen;
            ack_seen = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (ack !== 1'b0) ack_seen++;
            end
            check("bp_ack_low", ack_seen, 32'd0);
        end
        check("bp_data_held", {28'd0, rx_data},  32'h7);
        check("bp_cnt_held",  {16'd0, xfer_cnt}, 32'd1);
        rx_ready = 1'b1;
        tick();
        check("sim_valid", {31'd0, rx_valid}, 32'd1);
        check("sim_data",  {28'd0, rx_data},  32'h8);
        check("sim_cnt",   {16'd0, xfer_cnt}, 32'd2);
        check("sim_ack0",  {31'd0, ack},      32'd0);
        tick();
        check("sim_ack1",  {31'd0, ack},      32'd1);
        req = 1'b0;
        wait_ack(1'b0, "bp_ack_fall_timeout");
        mon_en = 1'b0;
        check("sim_words", got_q.size(), 32'd2);
        if (got_q.size() == 2) begin
            check("sim_word0", {28'd0, got_q[0]}, 32'h7);
            check("sim_word1", {28'd0, got_q[1]}, 32'h8);
        end

        // Sequence break 5, 6, 8, 9
        do_reset();
        rx_ready = 1'b1;
        send_word(4'h5);
        send_word(4'h6);
        check("seq_ok", {31'd0, seq_err}, 32'd0);
        data = 4'h8;
        req  = 1'b1;
        wait_valid("seq_valid_timeout");
        check("seq_break_data", {28'd0, rx_data}, 32'h8);
        check("seq_break_err",  {31'd0, seq_err}, 32'd1);
        wait_ack(1'b1, "seq_ack_rise_timeout");
        req = 1'b0;
        wait_ack(1'b0, "seq_ack_fall_timeout");
        send_word(4'h9);
        check("seq_sticky", {31'd0, seq_err}, 32'd1);

        // Wrap F -> 0 is legal
        do_reset();
        send_word(4'hF);
        send_word(4'h0);
        check("seq_wrap", {31'd0, seq_err}, 32'd0);

        // Reset while in WAIT_LOW with req still high
        send_word(4'h1);
        data = 4'hB;
        req  = 1'b1;
        wait_ack(1'b1, "rst_ack_timeout");
        rst = 1'b1;
        tick();
        check("rst_ack",   {31'd0, ack},      32'd0);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_data",  {28'd0, rx_data},  32'd0);
        check("rst_err",   {31'd0, seq_err},  32'd0);
        check("rst_cnt",   {16'd0, xfer_cnt}, 32'd0);
        rst = 1'b0;
        wait_valid("recap_timeout");
        check("recap_data", {28'd0, rx_data},  32'hB);
        check("recap_cnt",  {16'd0, xfer_cnt}, 32'd1);
        check("recap_err",  {31'd0, seq_err},  32'd0);
        wait_ack(1'b1, "recap_ack_timeout");
        req = 1'b0;
        wait_ack(1'b0, "recap_fall_timeout");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
